alu_cmd_sequencer: RTL and testbench

//  Initiator side of the ALU exec/oper/A/B/res_out interface. On start, reads N command

---
 rtl/alu_cmd_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: walks a batch of command words, issues each one to the ALU
// and stores the matching result at the same index of the result memory.
// Each command takes four cycles: FETCH, LATCH, EXEC and WRITE.
module alu_cmd_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter logic [15:0] ERROR_CODE = 16'hDEAD
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDR_WIDTH:0]           num_cmds,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_WIDTH:0]           err_count,
    output logic                          cmd_rd_en,
    output logic [ADDR_WIDTH-1:0]         cmd_addr,
    input  logic [3+2*DATA_WIDTH-1:0]     cmd_rdata,
    output logic                          alu_exec,
    output logic [2:0]                    alu_oper,
    output logic [DATA_WIDTH-1:0]         alu_a,
    output logic [DATA_WIDTH-1:0]         alu_b,
    input  logic [2*DATA_WIDTH-1:0]       alu_res,
    output logic                          res_wr_en,
    output logic [ADDR_WIDTH-1:0]         res_addr,
    output logic [2*DATA_WIDTH-1:0]       res_wdata
);

    localparam int unsigned RES_W = 2 * DATA_WIDTH;
    localparam int unsigned CMD_W = 3 + RES_W;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    // Largest batch the memories can hold, and the saturation point of err_count.
    localparam logic [CNT_W-1:0] MAX_N   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

    localparam logic [2:0] OP_DIV = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic [CNT_W-1:0]       err_count_q, err_count_d;
    logic [CMD_W-1:0]       cmd_q, cmd_d;

    logic [2:0]             cmd_oper;
    logic [DATA_WIDTH-1:0]  cmd_a;
    logic [DATA_WIDTH-1:0]  cmd_b;
    logic                   unsupported;
    logic                   err_hit;
    logic [CNT_W-1:0]       n_clamped;
    logic                   last_cmd;

    // Decode the latched command word and the per-command error conditions.
    always_comb begin
        cmd_oper    = cmd_q[CMD_W-1 -: 3];
        cmd_a       = cmd_q[RES_W-1 -: DATA_WIDTH];
        cmd_b       = cmd_q[DATA_WIDTH-1:0];
        unsupported = (cmd_oper > OP_DIV);
        err_hit     = unsupported || ((cmd_oper == OP_DIV) && (cmd_b == '0));
        n_clamped   = (num_cmds > MAX_N) ? MAX_N : num_cmds;
        last_cmd    = ({1'b0, idx_q} == (n_q - CNT_W'(1)));
    end

    // Next-state logic for the FSM and its datapath registers.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        idx_d       = idx_q;
        n_d         = n_q;
        err_count_d = err_count_q;
        cmd_d       = cmd_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d       = '0;
                    n_d         = n_clamped;
                    err_count_d = '0;
                    state_d     = (n_clamped == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                cmd_d   = cmd_rdata;
                state_d = S_EXEC;
            end
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: begin
                if (err_hit && (err_count_q != ERR_MAX)) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
                if (last_cmd) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort cancels the batch from any active state and freezes the datapath.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            idx_d       = idx_q;
            err_count_d = err_count_q;
            cmd_d       = cmd_q;
        end
    end

    // State and datapath registers, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            n_q         <= '0;
            err_count_q <= '0;
            cmd_q       <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            err_count_q <= err_count_d;
            cmd_q       <= cmd_d;
        end
    end

    // Interface outputs decoded from the current state; abort squashes this cycle's strobes.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE) && !abort;
        err_count = err_count_q;

        cmd_rd_en = (state_q == S_FETCH) && !abort;
        cmd_addr  = (state_q == S_FETCH) ? idx_q : '0;

        alu_exec  = (state_q == S_EXEC) && !unsupported && !abort;
        alu_oper  = (state_q == S_EXEC) ? cmd_oper : '0;
        alu_a     = (state_q == S_EXEC) ? cmd_a : '0;
        alu_b     = (state_q == S_EXEC) ? cmd_b : '0;

        res_wr_en = (state_q == S_WRITE) && !abort;
        res_addr  = (state_q == S_WRITE) ? idx_q : '0;
        res_wdata = '0;
        if (state_q == S_WRITE) begin
            res_wdata = unsupported ? RES_W'(ERROR_CODE) : alu_res;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed and randomized batches against a command-list
// reference model; models the command memory, the ALU and the result memory.
module tb_alu_cmd_sequencer;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [AW:0]       num_cmds = '0;
    logic              busy, done;
    logic [AW:0]       err_count;
    logic              cmd_rd_en;
    logic [AW-1:0]     cmd_addr;
    logic [3+2*DW-1:0] cmd_rdata = '0;
    logic              alu_exec;
    logic [2:0]        alu_oper;
    logic [DW-1:0]     alu_a, alu_b;
    logic [2*DW-1:0]   alu_res = '0;
    logic              res_wr_en;
    logic [AW-1:0]     res_addr;
    logic [2*DW-1:0]   res_wdata;

    alu_cmd_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERROR_CODE(16'hDEAD)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .num_cmds(num_cmds),
        .busy(busy), .done(done), .err_count(err_count),
        .cmd_rd_en(cmd_rd_en), .cmd_addr(cmd_addr), .cmd_rdata(cmd_rdata),
        .alu_exec(alu_exec), .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
        .res_wr_en(res_wr_en), .res_addr(res_addr), .res_wdata(res_wdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Command list seen by the DUT, and what the result memory captured.
    logic [2:0]       c_op [DEPTH];
    logic [DW-1:0]    c_a  [DEPTH];
    logic [DW-1:0]    c_b  [DEPTH];
    logic [2*DW-1:0]  res_mem [DEPTH];
    bit               written [DEPTH];
    int               wr_rel  [DEPTH];

    int cyc = 0, start_cyc = 0, done_rel = -1;
    int rd_cnt = 0, exec_cnt = 0, wr_cnt = 0, done_cnt = 0;

    // Behaviour of a real ALU for one operation.
    function automatic logic [2*DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        case (op)
            3'd0: return '0;
            3'd1: return 16'(a) + 16'(b);
            3'd2: return 16'(a) - 16'(b);
            3'd3: return 16'(a) * 16'(b);
            3'd4: return (b == '0) ? 16'hDEAD : 16'(a / b);
            default: return 16'h0BAD;
        endcase
    endfunction

    // Value the result memory must hold for one command.
    function automatic logic [2*DW-1:0] ref_result(input logic [2:0] op, input logic [DW-1:0] a,
                                                   input logic [DW-1:0] b);
        return (op >= 3'd5) ? 16'hDEAD : ref_alu(op, a, b);
    endfunction

    // Command memory: registered read, data valid the cycle after cmd_rd_en.
    always @(posedge clk) if (cmd_rd_en) cmd_rdata <= {c_op[cmd_addr], c_a[cmd_addr], c_b[cmd_addr]};

    // ALU: result valid the cycle after alu_exec.
    always @(posedge clk) if (alu_exec) alu_res <= ref_alu(alu_oper, alu_a, alu_b);

    // Result memory and traffic monitor; cycles are counted relative to the start edge.
    always @(posedge clk) begin
        if (start && !busy) start_cyc = cyc;
        if (cmd_rd_en) rd_cnt++;
        if (alu_exec) exec_cnt++;
        if (res_wr_en) begin
            wr_cnt++;
            res_mem[res_addr] = res_wdata;
            written[res_addr] = 1'b1;
            wr_rel[res_addr]  = cyc - start_cyc;
        end
        if (done) begin
            done_cnt++;
            done_rel = cyc - start_cyc;
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int i, input int op, input int a, input int b);
        c_op[i] = 3'(op);
        c_a[i]  = DW'(a);
        c_b[i]  = DW'(b);
    endtask

    // Pulse start for one cycle; returns in cycle 1 of the batch.
    task automatic start_batch(input int num);
        @(negedge clk);
        rd_cnt = 0; exec_cnt = 0; wr_cnt = 0; done_cnt = 0; done_rel = -1;
        for (int i = 0; i < DEPTH; i++) begin
            res_mem[i] = '0;
            written[i] = 1'b0;
            wr_rel[i]  = -1;
        end
        num_cmds = (AW+1)'(num);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic step(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    // Compare a completed batch of n commands against the reference model.
    task automatic check_batch(input string name, input int n);
        int errs = 0, execs = 0;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s res[%0d]", name, k), 32'(res_mem[k]), 32'(ref_result(c_op[k], c_a[k], c_b[k])));
            check($sformatf("%s wr_cycle[%0d]", name, k), 32'(wr_rel[k]), 32'(4*k+4));
            if (c_op[k] >= 3'd5 || (c_op[k] == 3'd4 && c_b[k] == '0)) errs++;
            if (c_op[k] <= 3'd4) execs++;
        end
        check({name, " rd_cnt"}, 32'(rd_cnt), 32'(n));
        check({name, " exec_cnt"}, 32'(exec_cnt), 32'(execs));
        check({name, " wr_cnt"}, 32'(wr_cnt), 32'(n));
        check({name, " err_count"}, 32'(err_count), 32'(errs));
        check({name, " done_cnt"}, 32'(done_cnt), 32'd1);
        check({name, " done_cycle"}, 32'(done_rel), 32'(4*n+1));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) set_cmd(i, 0, 0, 0);

        // Reset state
        step(3);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err_count", 32'(err_count), 32'd0);
        check("rst strobes", 32'({cmd_rd_en, alu_exec, res_wr_en}), 32'd0);
        check("rst alu_bus", 32'({alu_oper, alu_a, alu_b}), 32'd0);
        check("rst res_bus", 32'({res_addr, res_wdata}), 32'd0);
        reset_n = 1'b1;
        step(2);

        // 1: basic arithmetic
        set_cmd(0, 1, 5, 3); set_cmd(1, 2, 3, 5); set_cmd(2, 3, 200, 2);
        start_batch(3); wait_idle();
        check("t1 res0", 32'(res_mem[0]), 32'd8);
        check("t1 res1", 32'(res_mem[1]), 32'hFFFE);
        check("t1 res2", 32'(res_mem[2]), 32'd400);
        check_batch("t1", 3);

        // 2: divide by zero
        set_cmd(0, 4, 9, 0);
        start_batch(1); wait_idle();
        check("t2 res0", 32'(res_mem[0]), 32'hDEAD);
        check_batch("t2", 1);

        // 3: unsupported op then valid divide
        set_cmd(0, 6, 1, 1); set_cmd(1, 4, 20, 4);
        start_batch(2); wait_idle();
        check("t3 res1", 32'(res_mem[1]), 32'd5);
        check_batch("t3", 2);

        // 4: empty batch
        start_batch(0); wait_idle();
        check_batch("t4", 0);

        // 5: abort during EXEC of cmd1 (cycle 7)
        set_cmd(0, 7, 1, 2); set_cmd(1, 1, 3, 4); set_cmd(2, 2, 9, 9); set_cmd(3, 3, 15, 15);
        start_batch(4);
        step(6);
        abort = 1'b1;
        #1;
        check("t5 exec_squashed", 32'(alu_exec), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        check("t5 busy_after_abort", 32'(busy), 32'd0);
        step(3);
        check("t5 done_cnt", 32'(done_cnt), 32'd0);
        check("t5 wr_cnt", 32'(wr_cnt), 32'd1);
        check("t5 written", 32'({written[1], written[0]}), 32'd1);
        check("t5 res0", 32'(res_mem[0]), 32'hDEAD);
        check("t5 exec_cnt", 32'(exec_cnt), 32'd0);
        check("t5 err_held", 32'(err_count), 32'd1);
        start_batch(4); wait_idle();
        check_batch("t5 restart", 4);

        // 6a: start and num_cmds change while busy are ignored
        for (int i = 0; i < 5; i++) set_cmd(i, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
        start_batch(5);
        step(4);
        start = 1'b1; num_cmds = 2;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check_batch("t6 start_busy", 5);

        // 6b: reset during WRITE of cmd2 (cycle 12)
        start_batch(5);
        step(11);
        check("t6 in_write", 32'(res_wr_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6 rst busy", 32'(busy), 32'd0);
        check("t6 rst strobes", 32'({cmd_rd_en, alu_exec, res_wr_en, done}), 32'd0);
        check("t6 rst res_bus", 32'({res_addr, res_wdata}), 32'd0);
        check("t6 rst err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step(3);
        check("t6 not_resumed", 32'(busy), 32'd0);

        // 6c: num_cmds above depth clamps to 16 commands
        for (int i = 0; i < DEPTH; i++) set_cmd(i, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 3));
        start_batch(20); wait_idle();
        check_batch("t6 clamp", DEPTH);

        // Randomized batches
        for (int r = 0; r < 6; r++) begin
            int num, n_eff;
            num = $urandom_range(1, 2*DEPTH - 1);
            n_eff = (num > DEPTH) ? DEPTH : num;
            for (int i = 0; i < DEPTH; i++) begin
                set_cmd(i, $urandom_range(0, 7), $urandom_range(0, 255),
                        ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255));
            end
            start_batch(num);
            num_cmds = (AW+1)'($urandom_range(0, 2*DEPTH - 1));
            wait_idle();
            check_batch($sformatf("rnd%0d", r), n_eff);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
